// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8E1 UART receiver with run-time baud selection. Good frames
//               update DataOut; parity or framing errors pulse Mreset for one
//               clock so the remote transmitter can be reset or retried.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int unsigned DIV0 = 434,
    parameter int unsigned DIV1 = 217,
    parameter int unsigned DIV2 = 109,
    parameter int unsigned DIV3 = 72,
    parameter int unsigned DIV4 = 36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_in,
    input  logic [2:0] BC,
    output logic [7:0] DataOut,
    output logic       Mreset
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q;
    logic               rx_sync_q;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               mreset_q, mreset_d;

    logic [CNT_W-1:0]   div_sel;
    logic [CNT_W-1:0]   half_div;
    logic               bit_done;
    logic               half_done;
    logic               frame_good;

    // Baud divisor decode; unlisted codes fall back to the default rate
    always_comb begin
        div_sel = CNT_W'(DIV0);
        case (BC)
            3'b001:  div_sel = CNT_W'(DIV1);
            3'b010:  div_sel = CNT_W'(DIV2);
            3'b011:  div_sel = CNT_W'(DIV3);
            3'b100:  div_sel = CNT_W'(DIV4);
            default: div_sel = CNT_W'(DIV0);
        endcase
    end

    assign half_div   = div_q >> 1;
    assign half_done  = (cnt_q == half_div - CNT_W'(1));
    assign bit_done   = (cnt_q == div_q - CNT_W'(1));
    // Even parity: data XOR parity must be zero, and stop must be high
    assign frame_good = rx_sync_q && ((^shift_q ^ par_q) == 1'b0);

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            div_q      <= CNT_W'(DIV0);
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            data_out_q <= 8'h00;
            mreset_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            data_out_q <= data_out_d;
            mreset_q   <= mreset_d;
        end
    end

    // Next-state and datapath logic; all samples are taken at mid-bit
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        data_out_d = data_out_q;
        mreset_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Divisor only follows BC between frames
                div_d     = div_sel;
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_sync_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (half_done) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    par_d   = rx_sync_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (frame_good) begin
                        data_out_d = shift_q;
                    end else begin
                        mreset_d = 1'b1;
                    end
                    // A low stop bit means the line may be held low; do not
                    // re-arm start detection until it returns high
                    state_d = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign DataOut = data_out_q;
    assign Mreset  = mreset_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    logic       clk;
    logic       reset;
    logic       Rx_in;
    logic [2:0] BC;
    logic [7:0] DataOut;
    logic       Mreset;

    int passed;
    int total;
    int pulses;

    uart_receiver dut (
        .clk     (clk),
        .reset   (reset),
        .Rx_in   (Rx_in),
        .BC      (BC),
        .DataOut (DataOut),
        .Mreset  (Mreset)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count every clock on which Mreset is high; a single error pulse adds one
    always @(posedge clk) begin
        if (Mreset) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; BC is switched to bc_mid once the start bit is sent
    task automatic send_frame(input int n, input logic [7:0] data, input logic par,
                              input logic stop, input logic [2:0] bc_mid);
        Rx_in = 1'b0;
        wait_clks(n);
        BC = bc_mid;
        for (int i = 0; i < 8; i++) begin
            Rx_in = data[i];
            wait_clks(n);
        end
        Rx_in = par;
        wait_clks(n);
        Rx_in = stop;
        wait_clks(n);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        pulses = 0;
        reset  = 1'b0;
        Rx_in  = 1'b1;
        BC     = 3'b000;
        wait_clks(5);
        check("reset_dataout", {24'd0, DataOut}, 32'h00);
        check("reset_mreset", {31'd0, Mreset}, 32'd0);
        reset = 1'b1;
        wait_clks(20);

        // Default baud, byte 0x85 (three ones, parity 1)
        send_frame(434, 8'h85, 1'b1, 1'b1, 3'b000);
        wait_clks(20);
        check("default_85", {24'd0, DataOut}, 32'h85);
        check("default_no_pulse", pulses, 0);

        // Reset for one bit time clears the output
        reset = 1'b0;
        wait_clks(434);
        reset = 1'b1;
        wait_clks(2);
        check("reset2_dataout", {24'd0, DataOut}, 32'h00);
        check("reset2_mreset", {31'd0, Mreset}, 32'd0);

        // N=36, byte 0xCF (six ones, parity 0)
        BC = 3'b100;
        wait_clks(20);
        send_frame(36, 8'hCF, 1'b0, 1'b1, 3'b100);
        wait_clks(10);
        check("div4_cf", {24'd0, DataOut}, 32'hCF);
        check("div4_no_pulse", pulses, 0);

        // Framing error with the line held low well past the stop slot
        send_frame(36, 8'h00, 1'b0, 1'b0, 3'b100);
        wait_clks(36 * 15);
        check("frame_err_pulse", pulses, 1);
        check("frame_err_hold", {24'd0, DataOut}, 32'hCF);
        Rx_in = 1'b1;
        wait_clks(40);
        check("frame_err_after_high", pulses, 1);

        // Parity error at N=217: 0x07 has three ones, parity 0 is wrong
        BC = 3'b001;
        wait_clks(20);
        send_frame(217, 8'h07, 1'b0, 1'b1, 3'b001);
        wait_clks(20);
        check("parity_err_pulse", pulses, 2);
        check("parity_err_hold", {24'd0, DataOut}, 32'hCF);
        send_frame(217, 8'h07, 1'b1, 1'b1, 3'b001);
        wait_clks(20);
        check("parity_resend", {24'd0, DataOut}, 32'h07);
        check("parity_resend_no_pulse", pulses, 2);

        // Start glitch of N/4 clocks is rejected
        Rx_in = 1'b0;
        wait_clks(54);
        Rx_in = 1'b1;
        wait_clks(217 * 12);
        check("glitch_data", {24'd0, DataOut}, 32'h07);
        check("glitch_no_pulse", pulses, 2);

        // BC changed mid-frame: frame still decodes at N=217
        send_frame(217, 8'h5A, 1'b0, 1'b1, 3'b100);
        wait_clks(20);
        check("bc_change_5a", {24'd0, DataOut}, 32'h5A);
        check("bc_change_no_pulse", pulses, 2);

        // Back-to-back frames at the new rate (N=36)
        send_frame(36, 8'h3C, 1'b0, 1'b1, 3'b100);
        check("b2b_first", {24'd0, DataOut}, 32'h3C);
        send_frame(36, 8'hA1, 1'b1, 1'b1, 3'b100);
        wait_clks(5);
        check("b2b_second", {24'd0, DataOut}, 32'hA1);

        // N=109, all ones with even parity 0
        BC = 3'b010;
        wait_clks(20);
        send_frame(109, 8'hFF, 1'b0, 1'b1, 3'b010);
        wait_clks(10);
        check("div2_ff", {24'd0, DataOut}, 32'hFF);

        // Unlisted code 111 uses the default divisor
        BC = 3'b111;
        wait_clks(20);
        send_frame(434, 8'h01, 1'b1, 1'b1, 3'b111);
        wait_clks(20);
        check("code7_default", {24'd0, DataOut}, 32'h01);
        check("final_no_pulse", pulses, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Asynchronous serial (UART) receiver for 8-data-bit frames with an even-parity bit and one stop bit, sampled by a 50 MHz system clock. The baud rate is selected at run time from five fixed clocks-per-bit divisors. Valid bytes are presented on a parallel output. Corrupt frames (parity or stop-bit error) produce a request pulse that resets or retries the remote transmitter.

Parameters:
- DIV0, 434, clocks per bit for BC default codes (115200 baud at 50 MHz)
- DIV1, 217, clocks per bit for BC=3'b001
- DIV2, 109, clocks per bit for BC=3'b010
- DIV3, 72, clocks per bit for BC=3'b011
- DIV4, 36, clocks per bit for BC=3'b100

Ports:
- clk  in  1  system clock, 50 MHz, all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- Rx_in  in  1  serial line; idles high
- BC  in  3  baud select: 001→DIV1, 010→DIV2, 011→DIV3, 100→DIV4, any other value→DIV0
- DataOut  out  8  last correctly received byte
- Mreset  out  1  one-cycle high pulse on a bad frame; goes to the transmitter

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, DataOut=8'h00, Mreset=0, counters cleared, synchronizer flops set to 1. Reset overrides everything, including a frame in progress, which is discarded.
- Rx_in passes through a 2-flop synchronizer before use. All latencies below are counted from the synchronized signal.
- Divisor N is latched from BC only while in IDLE. A change of BC during a frame takes effect at the next frame.
- FSM states:
  - IDLE: wait for synchronized Rx=0 (falling edge), then go to START with the counter cleared.
  - START: count N/2 (integer) cycles, then sample. If Rx=0, go to DATA. If Rx=1 (glitch), return to IDLE with no output change.
  - DATA: sample every N cycles, 8 samples. Bits arrive LSB first into a shift register (first data bit → bit 0).
  - PARITY: sample the parity bit N cycles after D7.
  - STOP: sample N cycles after the parity bit.
    - Good frame (stop=1 and XOR of the 8 data bits and parity = 0): the cycle after the stop sample, DataOut takes the byte and Mreset stays 0.
    - Bad frame (parity mismatch or stop=0): DataOut holds its previous value and Mreset is 1 for exactly one clk.
    - Go to IDLE after the stop sample. If the stop bit was 0, wait for Rx=1 before re-arming start detection, so a held-low line does not retrigger.
- DataOut changes only on a good frame and is stable between frames.
- Sampling point is mid-bit. Tolerance is roughly ±40% of N of cumulative drift over the frame.
- Back-to-back frames: a start edge immediately after the stop sample is accepted.

Test Plan:
- Default baud (BC=000, N=434): idle high, then start, data 1,0,1,0,0,0,0,1 (LSB first), parity 1, stop 1, each 434 clk → DataOut=8'h85 about 1 clk after the stop sample; Mreset stays 0.
- Apply reset=0 for 1 bit time, then release → DataOut=8'h00, Mreset=0, FSM in IDLE.
- BC=100 (N=36): data 1,1,1,1,0,0,1,1, parity 0, stop 1 → DataOut=8'hCF, no Mreset pulse.
- BC=100: start, data all 0, parity 0, line held low through the stop slot → framing error: one-cycle Mreset=1, DataOut stays 8'hCF, and no new frame starts until the line returns high.
- Parity error at BC=001 (N=217): data 8'h07 with parity 0 → Mreset pulse, DataOut unchanged. Resend with parity 1 → DataOut=8'h07.
- Start glitch: Rx_in low for N/4 clk then high → no frame and no Mreset. Changing BC mid-frame → the current frame still decodes with the old N.
